muldiv_unit: RTL
================

# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, beside the ALU: takes the same rs1/rs2 operands and returns its result to the writeback result mux. It stalls the core via Busy for a fixed 32-cycle computation, then presents a one-cycle Done with Result valid for register writeback. It covers MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU, with RISC-V-defined divide-by-zero and overflow results.

## Interface
- No parameters; datapath fixed at 32 bits, iteration count fixed at 32.
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- Start  input  1  request; sampled on a rising edge only in IDLE or DONE.
- MulDivOp  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- A  input  32  rs1 operand (multiplicand / dividend).
- B  input  32  rs2 operand (multiplier / divisor).
- Busy  output  1  high while computing; the core stalls the PC and pipeline on Busy.
- Done  output  1  one-cycle pulse; Result valid during this cycle.
- Result  output  32  final result; held from DONE until the next accepted Start completes.
- Zero  output  1  (Result == 0), combinational from Result.

## Operation
- States:
  - IDLE: Start=1 latches MulDivOp, A and B, clears the counter, goes to RUN; Start=0 stays in IDLE.
  - RUN: one iteration per cycle, counter 0..31; at count 31 goes to DONE.
  - DONE: Result registered, Done=1; Start=1 behaves exactly as in IDLE (back-to-back op); otherwise returns to IDLE.
- Operand inputs and Start are ignored in RUN; the latched copies are used.
- Sign prep at latch time:
  - Signed operands are MUL/MULH for A and B, MULHSU for A only, DIV/REM for both.
  - Signed operands are converted to magnitudes; the result sign is recorded.
- Multiply: shift-add over 64-bit product.
  - The negative-result fix-up is a 64-bit two's complement.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- Divide: restoring, 1 quotient bit per cycle.
  - Quotient sign = sign(A) xor sign(B).
  - Remainder sign = sign(A).
  - Results truncate toward zero.
- Special cases are resolved at latch time, but the unit still runs the full 32 cycles (fixed latency):
  - B=0, DIV/DIVU: Result=0xFFFFFFFF.
  - B=0, REM/REMU: Result=A.
  - DIV with A=0x80000000, B=0xFFFFFFFF: Result=0x80000000.
  - REM with the same operands: Result=0.
- All arithmetic is modulo 2^32 (2^64 for the product); no exceptions or flags beyond Zero.

## Timing
- Reset (rst_n=0, any time, including mid-RUN): state=IDLE, counter=0, Busy=0, Done=0, Result=0, Zero=1; the in-flight op is discarded.
- Start sampled at edge E0 → Busy=1 from E0 through E32.
- DONE cycle follows edge E32: Busy=0, Done=1, Result valid.
- Latency: 33 cycles from the accepting edge to Done; the core's writeback occurs at E33.
- Back-to-back: Start=1 during DONE is accepted at E33. Done drops and Busy rises after E33, and Result keeps the previous value until the new DONE.
- Busy and Done are never high together. Done is high for exactly one cycle per accepted Start.
- Result changes only on entry to DONE or on reset.

## Test plan
- Reset and basic MUL:
  - Deassert rst_n, then MUL A=7, B=0xFFFFFFFD (−3).
  - Expect Busy high for 32 cycles, Done at cycle 33, Result=0xFFFFFFEB, Zero=0.
- High multiplies:
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide:
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
- Edge cases, each with full 33-cycle latency:
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM same operands → 0 with Zero=1.
- Handshake:
  - Start pulsed and operands changed during RUN → ignored; original result delivered.
  - Start held during DONE → second op accepted; both Done pulses are one cycle, 33 cycles apart.
- Asynchronous reset:
  - rst_n asserted at count 15 of a DIV → outputs go to reset values immediately, with no Done pulse.
  - Next Start after release completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with fixed 33-cycle latency
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   Start           request, accepted only in IDLE or DONE
//   MulDivOp[2:0]   RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   A[31:0], B[31:0] rs1 / rs2 operands
//   Busy            high while iterating (32 cycles)
//   Done            one-cycle pulse, Result valid
//   Result[31:0]    registered result, held until the next completion
//   Zero            Result == 0
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [2:0]  MulDivOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Result,
    output logic        Zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    // Shared working register: {accumulator, multiplier} for multiply,
    // {partial remainder, dividend/quotient} for divide.
    logic [63:0] prod_q, prod_d;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [31:0] opnd_q, opnd_d;
    logic        neg_q, neg_d;
    logic        special_q, special_d;
    logic [31:0] special_val_q, special_val_d;
    logic [31:0] result_q, result_d;

    // Operand preparation at accept time
    logic        sign_a, sign_b;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;

    // Iteration datapath
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] rem_sh;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] step_next;

    // Final result formation
    logic [63:0] mul_fix;
    logic [31:0] mul_res;
    logic [31:0] div_raw;
    logic [31:0] div_res;
    logic [31:0] final_res;

    always_comb begin
        sign_a = (MulDivOp == OP_MUL) || (MulDivOp == OP_MULH) ||
                 (MulDivOp == OP_MULHSU) || (MulDivOp == OP_DIV) ||
                 (MulDivOp == OP_REM);
        sign_b = (MulDivOp == OP_MUL) || (MulDivOp == OP_MULH) ||
                 (MulDivOp == OP_DIV) || (MulDivOp == OP_REM);
        a_neg  = sign_a && A[31];
        b_neg  = sign_b && B[31];
        a_mag  = a_neg ? (~A + 32'd1) : A;
        b_mag  = b_neg ? (~B + 32'd1) : B;
    end

    always_comb begin
        // Shift-add: add multiplicand into the upper half when the current
        // multiplier bit is set, then shift the whole 64-bit product right.
        mul_sum  = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_next = {mul_sum, prod_q[31:1]};

        // Restoring divide: bring the next dividend bit into the remainder,
        // keep the subtraction only if it did not go negative.
        rem_sh   = prod_q[63:31];
        div_diff = rem_sh - {1'b0, opnd_q};
        if (!div_diff[32]) begin
            div_next = {div_diff[31:0], prod_q[30:0], 1'b1};
        end else begin
            div_next = {rem_sh[31:0], prod_q[30:0], 1'b0};
        end

        step_next = op_q[2] ? div_next : mul_next;

        mul_fix = neg_q ? (~step_next + 64'd1) : step_next;
        mul_res = (op_q == OP_MUL) ? mul_fix[31:0] : mul_fix[63:32];

        div_raw = op_q[1] ? step_next[63:32] : step_next[31:0];
        div_res = neg_q ? (~div_raw + 32'd1) : div_raw;

        if (special_q) begin
            final_res = special_val_q;
        end else if (op_q[2]) begin
            final_res = div_res;
        end else begin
            final_res = mul_res;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        prod_d        = prod_q;
        opnd_d        = opnd_q;
        neg_d         = neg_q;
        special_d     = special_q;
        special_val_d = special_val_q;
        result_d      = result_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (Start) begin
                    state_d = S_RUN;
                    cnt_d   = 5'd0;
                    op_d    = MulDivOp;
                    if (MulDivOp[2]) begin
                        prod_d = {32'd0, a_mag};
                        opnd_d = b_mag;
                        // Remainder takes the dividend's sign, quotient the xor.
                        neg_d  = MulDivOp[1] ? a_neg : (a_neg ^ b_neg);
                    end else begin
                        prod_d = {32'd0, b_mag};
                        opnd_d = a_mag;
                        neg_d  = a_neg ^ b_neg;
                    end
                    // Divide-by-zero and signed overflow are fixed here; the
                    // iterations still run so latency never varies.
                    special_d     = 1'b0;
                    special_val_d = 32'd0;
                    if (MulDivOp[2] && (B == 32'd0)) begin
                        special_d     = 1'b1;
                        special_val_d = MulDivOp[1] ? A : 32'hFFFF_FFFF;
                    end else if (((MulDivOp == OP_DIV) || (MulDivOp == OP_REM)) &&
                                 (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF)) begin
                        special_d     = 1'b1;
                        special_val_d = MulDivOp[1] ? 32'd0 : 32'h8000_0000;
                    end
                end
            end
            S_RUN: begin
                prod_d = step_next;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d  = S_DONE;
                    cnt_d    = 5'd0;
                    result_d = final_res;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= 5'd0;
            op_q          <= 3'd0;
            prod_q        <= 64'd0;
            opnd_q        <= 32'd0;
            neg_q         <= 1'b0;
            special_q     <= 1'b0;
            special_val_q <= 32'd0;
            result_q      <= 32'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            prod_q        <= prod_d;
            opnd_q        <= opnd_d;
            neg_q         <= neg_d;
            special_q     <= special_d;
            special_val_q <= special_val_d;
            result_q      <= result_d;
        end
    end

    assign Busy   = (state_q == S_RUN);
    assign Done   = (state_q == S_DONE);
    assign Result = result_q;
    assign Zero   = (result_q == 32'd0);

endmodule
